// File: rtl/game_controller.sv
// Purpose: game sequencer (IDLE -> COUNTDOWN -> PLAY -> OVER) with shared tick prescaler and hit scoring.
// Latency: start edge / hit take effect one cycle after being sampled; status outputs decode registered state.
// Backpressure: none; start_game and hit are sampled every cycle and ignored in states that do not use them.
// Optional feature macro: GAME_HIGH_SCORE_EN adds high_score / new_record outputs.
module game_controller #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int COUNT_TICKS = 3,
    parameter int ROUND_TICKS = 30,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               game_reset,
    input  logic               start_game,
    input  logic               hit,
    output logic               game_flag,
    output logic               game_over,
    output logic [1:0]         state,
    output logic               tick,
    output logic [3:0]         countdown,
    output logic [7:0]         time_left,
    output logic [SCORE_W-1:0] score
`ifdef GAME_HIGH_SCORE_EN
    ,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_record
`endif
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_PLAY      = 2'd2,
        S_OVER      = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               start_q;
    logic               start_edge;
    logic               running;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_cnt_d;
    logic [3:0]         countdown_d;
    logic [7:0]         time_left_d;
    logic [SCORE_W-1:0] score_d;

    // start_q resets high so a button held through reset is not seen as a press
    assign start_edge = start_game & ~start_q;
    assign running    = (state_q == S_COUNTDOWN) || (state_q == S_PLAY);
    assign tick       = running && (div_cnt == DIV_LAST);

    // Status outputs are pure decodes of the state register
    assign state     = state_q;
    assign game_flag = (state_q == S_PLAY);
    assign game_over = (state_q == S_OVER);

    // Next-state, counter loads and scoring
    always_comb begin
        state_d     = state_q;
        countdown_d = countdown;
        time_left_d = time_left;
        score_d     = score;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    state_d     = S_COUNTDOWN;
                    countdown_d = 4'(COUNT_TICKS);
                    time_left_d = 8'(ROUND_TICKS);
                    score_d     = '0;
                end
            end
            S_COUNTDOWN: begin
                if (tick) begin
                    countdown_d = countdown - 4'd1;
                    if (countdown == 4'd1) begin
                        state_d = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                // a hit on the final tick cycle is still counted
                if (hit && (score != '1)) begin
                    score_d = score + SCORE_W'(1);
                end
                if (tick) begin
                    time_left_d = time_left - 8'd1;
                    if (time_left == 8'd1) begin
                        state_d = S_OVER;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // prescaler restarts on every state change so each phase gets whole ticks
        if ((state_d != state_q) || !running || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt + DIV_W'(1);
        end
    end

`ifdef GAME_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score_d;
    logic               new_record_d;

    // Record check on round end using the final score including a same-cycle hit
    always_comb begin
        high_score_d = high_score;
        new_record_d = new_record;
        if ((state_q == S_PLAY) && (state_d == S_OVER)) begin
            if (score_d > high_score) begin
                high_score_d = score_d;
                new_record_d = 1'b1;
            end else begin
                new_record_d = 1'b0;
            end
        end else if ((state_q == S_OVER) && (state_d != S_OVER)) begin
            new_record_d = 1'b0;
        end
    end

    // High score persists across rounds; only reset clears it
    always_ff @(posedge clk) begin
        if (game_reset) begin
            high_score <= '0;
            new_record <= 1'b0;
        end else begin
            high_score <= high_score_d;
            new_record <= new_record_d;
        end
    end
`endif

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (game_reset) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b1;
            div_cnt   <= '0;
            countdown <= '0;
            time_left <= '0;
            score     <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_game;
            div_cnt   <= div_cnt_d;
            countdown <= countdown_d;
            time_left <= time_left_d;
            score     <= score_d;
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Purpose: randomized and directed bench for game_controller against a phase/age reference model.
// Latency: every input step is followed by a full output comparison 1 ns after the rising edge.
// Backpressure: not applicable; inputs are driven freely each cycle.
module tb_game_controller;

    localparam int TD      = 4;
    localparam int CT      = 3;
    localparam int RT      = 5;
    localparam int SW      = 4;
    localparam int MAXSC   = (1 << SW) - 1;

    logic          clk;
    logic          game_reset;
    logic          start_game;
    logic          hit;
    logic          game_flag;
    logic          game_over;
    logic [1:0]    state;
    logic          tick;
    logic [3:0]    countdown;
    logic [7:0]    time_left;
    logic [SW-1:0] score;
`ifdef GAME_HIGH_SCORE_EN
    logic [SW-1:0] high_score;
    logic          new_record;
`endif

    int total = 0;
    int bad   = 0;

    // reference model: current phase, cycles spent in it, and game bookkeeping
    int m_phase;
    int m_age;
    int m_score;
    int m_prev;
    int m_hs;
    int m_rec;

    game_controller #(
        .TICK_DIV(TD), .COUNT_TICKS(CT), .ROUND_TICKS(RT), .SCORE_W(SW)
    ) dut (
        .clk(clk), .game_reset(game_reset), .start_game(start_game), .hit(hit),
        .game_flag(game_flag), .game_over(game_over), .state(state), .tick(tick),
        .countdown(countdown), .time_left(time_left), .score(score)
`ifdef GAME_HIGH_SCORE_EN
        , .high_score(high_score), .new_record(new_record)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic h);
        int edge_seen;
        if (rst) begin
            m_phase = 0; m_age = 0; m_score = 0; m_prev = 1; m_hs = 0; m_rec = 0;
            return;
        end
        edge_seen = (st && !m_prev) ? 1 : 0;
        m_prev    = st ? 1 : 0;
        case (m_phase)
            1: begin
                m_age++;
                if (m_age == CT * TD) begin m_phase = 2; m_age = 0; end
            end
            2: begin
                if (h && m_score < MAXSC) m_score++;
                m_age++;
                if (m_age == RT * TD) begin
                    m_phase = 3; m_age = 0;
                    if (m_score > m_hs) begin m_hs = m_score; m_rec = 1; end
                    else m_rec = 0;
                end
            end
            default: begin
                if (edge_seen) begin
                    m_phase = 1; m_age = 0; m_score = 0; m_rec = 0;
                end else begin
                    m_age++;
                end
            end
        endcase
    endtask

    task automatic check_all();
        int e_cd;
        int e_tl;
        int e_tick;
        e_cd   = (m_phase == 1) ? CT - m_age / TD : 0;
        e_tl   = (m_phase == 1) ? RT : (m_phase == 2) ? RT - m_age / TD : 0;
        e_tick = ((m_phase == 1 || m_phase == 2) && (m_age % TD == TD - 1)) ? 1 : 0;
        chk("state",     32'(state),     32'(m_phase));
        chk("game_flag", 32'(game_flag), (m_phase == 2) ? 32'd1 : 32'd0);
        chk("game_over", 32'(game_over), (m_phase == 3) ? 32'd1 : 32'd0);
        chk("tick",      32'(tick),      32'(e_tick));
        chk("countdown", 32'(countdown), 32'(e_cd));
        chk("time_left", 32'(time_left), 32'(e_tl));
        chk("score",     32'(score),     32'(m_score));
`ifdef GAME_HIGH_SCORE_EN
        chk("high_score", 32'(high_score), 32'(m_hs));
        chk("new_record", 32'(new_record), 32'(m_rec));
`endif
    endtask

    task automatic step(input logic rst, input logic st, input logic h);
        @(negedge clk);
        game_reset = rst;
        start_game = st;
        hit        = h;
        @(posedge clk);
        model_edge(rst, st, h);
        #1;
        check_all();
    endtask

    task automatic start_press();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    // countdown with junk start/hit traffic, then PLAY with hits taken from mask
    task automatic run_round(input logic [31:0] mask);
        int g;
        g = 0;
        while (m_phase == 1 && g < 100) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            g++;
        end
        chk("reach_play", 32'(state), 32'd2);
        g = 0;
        while (m_phase == 2 && g < 100) begin
            step(1'b0, 1'($urandom_range(0, 1)), (g < 32) ? mask[g] : 1'b0);
            g++;
        end
        chk("play_cycles", 32'(g), 32'(RT * TD));
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        game_reset = 1'b1;
        start_game = 1'b0;
        hit        = 1'b0;
        model_edge(1'b1, 1'b0, 1'b0);

        // reset for 4 cycles, then ignored hits in IDLE
        repeat (4) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);

        // first round: 3 hits, the last on the final tick cycle
        start_press();
        chk("start_cd", 32'(state), 32'd1);
        run_round(32'h0008_0011);
        chk("round1_score", 32'(score), 32'd3);
        chk("round1_over", 32'(game_over), 32'd1);

        // restart from OVER clears score
        start_press();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_score", 32'(score), 32'd0);
        run_round($urandom);

        // button held through reset release does not start a game
        repeat (2) step(1'b1, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b1);
        chk("held_idle", 32'(state), 32'd0);
        start_press();
        run_round(32'h000F_FFFF);
        chk("sat_score", 32'(score), 32'(MAXSC));

        // reset mid-PLAY
        start_press();
        while (m_phase == 1) step(1'b0, 1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("midreset_state", 32'(state), 32'd0);
        chk("midreset_score", 32'(score), 32'd0);
        chk("midreset_flag", 32'(game_flag), 32'd0);

        // record tracking over rounds scoring 4, 2, 6
        step(1'b1, 1'b0, 1'b0);
        start_press();
        run_round(32'h0000_000F);
`ifdef GAME_HIGH_SCORE_EN
        chk("hs_round_a", 32'(high_score), 32'd4);
        chk("rec_round_a", 32'(new_record), 32'd1);
`endif
        start_press();
        run_round(32'h0000_0003);
`ifdef GAME_HIGH_SCORE_EN
        chk("hs_round_b", 32'(high_score), 32'd4);
        chk("rec_round_b", 32'(new_record), 32'd0);
`endif
        start_press();
        run_round(32'h0000_003F);
`ifdef GAME_HIGH_SCORE_EN
        chk("hs_round_c", 32'(high_score), 32'd6);
        chk("rec_round_c", 32'(new_record), 32'd1);
`endif
        chk("round_c_score", 32'(score), 32'd6);

        // random soak
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
